// File: rtl/fp_unpack_seq.sv
// fp_unpack_seq: handshaked IEEE-754 operand classifier and unpacker.
// Accepts one half/single/double operand per transaction, registers its
// class flags, RISC-V style class mask, sign and tag, and unpacks it into a
// signed unbiased exponent plus a mantissa with explicit hidden bit.
// Subnormals are normalised by a binary-search shifter, one step per cycle,
// unless denormals-are-zero mode flushes them to a zero value.
module fp_unpack_seq #(
  parameter int   PRECISION   = 16,
  parameter bit   DAZ         = 1'b0,
  parameter int   TAG_W       = 4,
  localparam int  EXP_LEN     = (PRECISION == 16) ? 5  : (PRECISION == 32) ? 8  : 11,
  localparam int  MAN_LEN     = (PRECISION == 16) ? 10 : (PRECISION == 32) ? 23 : 52,
  localparam int  BUF_MAN_LEN = MAN_LEN + 1,
  localparam int  BUF_EXP_LEN = EXP_LEN + 2,
  localparam int  BIAS        = (1 << (EXP_LEN - 1)) - 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PRECISION-1:0]          f,
  input  logic [TAG_W-1:0]              in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          fSign,
  output logic signed [BUF_EXP_LEN-1:0] fExp,
  output logic [BUF_MAN_LEN-1:0]        fMan,
  output logic                          SNaN,
  output logic                          QNaN,
  output logic                          Infinity,
  output logic                          Zero,
  output logic                          Subnormal,
  output logic                          Normal,
  output logic [9:0]                    fclass,
  output logic [TAG_W-1:0]              out_tag
);

  // Number of binary-search steps: shifts of 2^(K-1) .. 1 cover any
  // leading-zero count of the {0, fraction} mantissa.
  localparam int K     = $clog2(BUF_MAN_LEN);
  localparam int CNT_W = $clog2(K + 1);

  if (!(PRECISION == 16 || PRECISION == 32 || PRECISION == 64)) begin : g_bad_precision
    $fatal(1, "fp_unpack_seq: PRECISION must be 16, 32 or 64");
  end

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t                 state, state_nxt;
  logic                   accept;
  logic [CNT_W-1:0]       cnt;

  // Operand field decode.
  logic [EXP_LEN-1:0]     exp_f;
  logic [MAN_LEN-1:0]     frac;
  logic                   exp_ones, exp_zeros, frac_zero;
  logic                   d_sign, d_snan, d_qnan, d_inf, d_zero, d_sub, d_norm;
  logic [9:0]             d_fclass;
  logic [BUF_EXP_LEN-1:0] d_exp;
  logic [BUF_MAN_LEN-1:0] d_man;
  logic                   go_norm;

  // Normalisation step.
  logic [BUF_MAN_LEN-1:0] sh;
  logic                   top_zero;

  assign exp_f     = f[PRECISION-2 -: EXP_LEN];
  assign frac      = f[MAN_LEN-1:0];
  assign d_sign    = f[PRECISION-1];
  assign exp_ones  = &exp_f;
  assign exp_zeros = ~|exp_f;
  assign frac_zero = ~|frac;

  assign d_snan = exp_ones & ~frac_zero & ~frac[MAN_LEN-1];
  assign d_qnan = exp_ones & frac[MAN_LEN-1];
  assign d_inf  = exp_ones & frac_zero;
  assign d_zero = exp_zeros & frac_zero;
  assign d_sub  = exp_zeros & ~frac_zero;
  assign d_norm = ~exp_ones & ~exp_zeros;

  assign d_fclass = {d_qnan, d_snan,
                     ~d_sign & d_inf, ~d_sign & d_norm, ~d_sign & d_sub, ~d_sign & d_zero,
                      d_sign & d_zero, d_sign & d_sub,  d_sign & d_norm, d_sign & d_inf};

  // Only subnormals without flush need the normalisation pass.
  assign go_norm = d_sub & ~DAZ;
  assign accept  = in_valid & in_ready;

  // Initial exponent/mantissa for the decoded operand class.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    d_exp = {2'b00, exp_f};
    d_man = {1'b0, frac};
    if (d_norm) begin
      d_exp = {2'b00, exp_f} - BUF_EXP_LEN'(BIAS);
      d_man = {1'b1, frac};
    end else if (d_sub) begin
      if (DAZ) begin
        d_exp = '0;
        d_man = '0;
      end else begin
        d_exp = BUF_EXP_LEN'(1 - BIAS);
      end
    end
  end

  // Current step shifts by 2^(cnt-1) if the top 2^(cnt-1) mantissa bits are clear.
  always_comb begin
    sh       = BUF_MAN_LEN'(1) << (cnt - CNT_W'(1));
    top_zero = ~|(fMan & ~({BUF_MAN_LEN{1'b1}} >> sh));
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = go_norm ? NORM : DONE;
      end
      NORM: begin
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? (go_norm ? NORM : DONE) : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers: load on accept, shift during normalisation, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      fSign     <= 1'b0;
      fExp      <= '0;
      fMan      <= '0;
      SNaN      <= 1'b0;
      QNaN      <= 1'b0;
      Infinity  <= 1'b0;
      Zero      <= 1'b0;
      Subnormal <= 1'b0;
      Normal    <= 1'b0;
      fclass    <= '0;
      out_tag   <= '0;
    end else if (accept) begin
      cnt       <= CNT_W'(K);
      fSign     <= d_sign;
      fExp      <= d_exp;
      fMan      <= d_man;
      SNaN      <= d_snan;
      QNaN      <= d_qnan;
      Infinity  <= d_inf;
      Zero      <= d_zero;
      Subnormal <= d_sub;
      Normal    <= d_norm;
      fclass    <= d_fclass;
      out_tag   <= in_tag;
    end else if (state == NORM) begin
      if (top_zero) begin
        fMan <= fMan << sh;
        fExp <= fExp - BUF_EXP_LEN'(sh);
      end
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule
